// File: rtl/rv_ctrl_pkg.sv
// Shared control-bundle layout, ALU op codes and ID/EX stage state encoding
// for the pipelined RV32I core.
package rv_ctrl_pkg;

    localparam int unsigned CTRL_W = 12;

    localparam int unsigned CtrlRegWrite = 0;
    localparam int unsigned CtrlMemRead  = 1;
    localparam int unsigned CtrlMemWrite = 2;
    localparam int unsigned CtrlMemtoReg = 3;
    localparam int unsigned CtrlAluSrc   = 4;
    localparam int unsigned CtrlAluOpLo  = 5;
    localparam int unsigned CtrlAluOpHi  = 6;
    localparam int unsigned CtrlBranch   = 7;
    localparam int unsigned CtrlJal      = 8;
    localparam int unsigned CtrlJalr     = 9;
    localparam int unsigned CtrlAuipc    = 10;
    localparam int unsigned CtrlHalt     = 11;

    typedef enum logic [1:0] {
        AluOpAdd    = 2'b00,
        AluOpBranch = 2'b01,
        AluOpRType  = 2'b10,
        AluOpIType  = 2'b11
    } alu_op_e;

    // Field order mirrors the bit indices above, MSB first.
    typedef struct packed {
        logic       halt;
        logic       auipc;
        logic       jalr;
        logic       jal;
        logic       branch;
        logic [1:0] alu_op;
        logic       alu_src;
        logic       mem_to_reg;
        logic       mem_write;
        logic       mem_read;
        logic       reg_write;
    } ctrl_t;

    typedef enum logic {
        StRun    = 1'b0,
        StHalted = 1'b1
    } state_e;

    localparam ctrl_t CtrlBubble = '0;

endpackage

// File: rtl/id_ex_ctrl_stage_if.sv
// ID-side inputs and EX-side outputs of the ID/EX control stage.
// The master drives the decode side; the slave is the pipeline stage.
interface id_ex_ctrl_stage_if #(
    parameter int unsigned CNT_W = 16
);
    import rv_ctrl_pkg::*;

    logic              id_valid;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_is_fence;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rd;
    logic              flush;

    logic              ex_valid;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [4:0]        ex_rs1;
    logic [4:0]        ex_rs2;
    logic [4:0]        ex_rd;
    logic              pc_stall;
    logic              halted;
    logic [CNT_W-1:0]  bubble_count;

    modport master (
        output id_valid, id_ctrl, id_is_fence, id_rs1, id_rs2, id_rd, flush,
        input  ex_valid, ex_ctrl, ex_rs1, ex_rs2, ex_rd, pc_stall, halted, bubble_count
    );

    modport slave (
        input  id_valid, id_ctrl, id_is_fence, id_rs1, id_rs2, id_rd, flush,
        output ex_valid, ex_ctrl, ex_rs1, ex_rs2, ex_rd, pc_stall, halted, bubble_count
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use and halt-in-EX detection for the ID/EX stage.
module hazard_detect (
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic       ex_halt_i,
    input  logic [4:0] ex_rd_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    output logic       lu_o,
    output logic       hx_o
);

    logic rd_nonzero;
    logic rs_match;

    assign rd_nonzero = (ex_rd_i != 5'd0);
    // rs2 is compared for every format; the occasional false stall is accepted.
    assign rs_match   = (ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i);

    assign lu_o = ex_valid_i & ex_mem_read_i & rd_nonzero & id_valid_i & rs_match;
    assign hx_o = ex_valid_i & ex_halt_i;

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control pipeline register: load-use stall, redirect squash,
// sticky halt on ECALL/EBREAK/FENCE and a saturating bubble counter.
module id_ex_ctrl_stage
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W         = 16,
    parameter bit          HALT_ON_FENCE = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    id_ex_ctrl_stage_if.slave   ctrl_io
);

    state_e           state_q, state_d;
    logic             ex_valid_q, ex_valid_d;
    ctrl_t            ex_ctrl_q, ex_ctrl_d;
    logic [4:0]       ex_rs1_q, ex_rs1_d;
    logic [4:0]       ex_rs2_q, ex_rs2_d;
    logic [4:0]       ex_rd_q, ex_rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    ctrl_t id_ctrl;
    logic  cnt_inc;
    logic  pc_stall;
    logic  lu;
    logic  hx;

    assign id_ctrl = ctrl_io.id_ctrl;

    hazard_detect u_hazard_detect (
        .ex_valid_i    (ex_valid_q),
        .ex_mem_read_i (ex_ctrl_q.mem_read),
        .ex_halt_i     (ex_ctrl_q.halt),
        .ex_rd_i       (ex_rd_q),
        .id_valid_i    (ctrl_io.id_valid),
        .id_rs1_i      (ctrl_io.id_rs1),
        .id_rs2_i      (ctrl_io.id_rs2),
        .lu_o          (lu),
        .hx_o          (hx)
    );

    always_comb begin
        state_d    = state_q;
        ex_valid_d = 1'b0;
        ex_ctrl_d  = CtrlBubble;
        ex_rs1_d   = 5'd0;
        ex_rs2_d   = 5'd0;
        ex_rd_d    = 5'd0;
        cnt_inc    = 1'b0;
        pc_stall   = 1'b0;

        unique case (state_q)
            StRun: begin
                if (ctrl_io.flush) begin
                    // A halt sitting in EX is wrong-path here and simply dropped.
                    cnt_inc = 1'b1;
                end else if (hx) begin
                    pc_stall = 1'b1;
                    state_d  = StHalted;
                end else if (lu) begin
                    pc_stall = 1'b1;
                    cnt_inc  = 1'b1;
                end else if (ctrl_io.id_valid) begin
                    ex_valid_d = 1'b1;
                    ex_ctrl_d  = id_ctrl;
                    ex_rs1_d   = ctrl_io.id_rs1;
                    ex_rs2_d   = ctrl_io.id_rs2;
                    ex_rd_d    = ctrl_io.id_rd;
                    if (ctrl_io.id_is_fence && !HALT_ON_FENCE) begin
                        ex_ctrl_d.halt = 1'b0;
                    end
                end
            end
            StHalted: begin
                pc_stall = 1'b1;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= CtrlBubble;
            ex_rs1_q   <= 5'd0;
            ex_rs2_q   <= 5'd0;
            ex_rd_q    <= 5'd0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            ex_rs1_q   <= ex_rs1_d;
            ex_rs2_q   <= ex_rs2_d;
            ex_rd_q    <= ex_rd_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ctrl_io.ex_valid     = ex_valid_q;
    assign ctrl_io.ex_ctrl      = ex_ctrl_q;
    assign ctrl_io.ex_rs1       = ex_rs1_q;
    assign ctrl_io.ex_rs2       = ex_rs2_q;
    assign ctrl_io.ex_rd        = ex_rd_q;
    assign ctrl_io.pc_stall     = pc_stall;
    assign ctrl_io.halted       = (state_q == StHalted);
    assign ctrl_io.bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Directed bench for id_ex_ctrl_stage with a 4-bit bubble counter and
// HALT_ON_FENCE=0.
module tb_id_ex_ctrl_stage;

    localparam int unsigned CntW = 4;

    localparam logic [11:0] CtrlLoad  = 12'h01B;
    localparam logic [11:0] CtrlAdd   = 12'h041;
    localparam logic [11:0] CtrlEcall = 12'h800;
    localparam logic [11:0] CtrlHLoad = 12'h802;
    localparam logic [11:0] CtrlImm   = 12'h071;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    id_ex_ctrl_stage_if #(.CNT_W(CntW)) bus ();

    id_ex_ctrl_stage #(
        .CNT_W         (CntW),
        .HALT_ON_FENCE (1'b0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctrl_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input logic v, input logic [11:0] c, input logic fence,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic fl);
        bus.id_valid    = v;
        bus.id_ctrl     = c;
        bus.id_is_fence = fence;
        bus.id_rs1      = rs1;
        bus.id_rs2      = rs2;
        bus.id_rd       = rd;
        bus.flush       = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        drive(1'b0, 12'h000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        check_eq("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
        check_eq("rst_ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
        check_eq("rst_halted", 32'(bus.halted), 32'd0);
        check_eq("rst_bubbles", 32'(bus.bubble_count), 32'd0);
        check_eq("rst_pc_stall", 32'(bus.pc_stall), 32'd0);
        #11 rst_n = 1'b1;

        // Load x5 into EX, then dependent add in ID.
        drive(1'b1, CtrlLoad, 1'b0, 5'd1, 5'd2, 5'd5, 1'b0);
        tick();
        check_eq("load_ex_valid", 32'(bus.ex_valid), 32'd1);
        check_eq("load_ex_ctrl", 32'(bus.ex_ctrl), 32'h01B);
        check_eq("load_ex_rd", 32'(bus.ex_rd), 32'd5);
        check_eq("load_ex_rs2", 32'(bus.ex_rs2), 32'd2);
        drive(1'b1, CtrlAdd, 1'b0, 5'd5, 5'd6, 5'd7, 1'b0);
        #1;
        check_eq("lu_rs1_stall", 32'(bus.pc_stall), 32'd1);
        tick();
        check_eq("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
        check_eq("lu_bubble_ctrl", 32'(bus.ex_ctrl), 32'd0);
        check_eq("lu_bubble_rd", 32'(bus.ex_rd), 32'd0);
        check_eq("lu_count", 32'(bus.bubble_count), 32'd1);
        check_eq("lu_stall_released", 32'(bus.pc_stall), 32'd0);
        tick();
        check_eq("add_ex_valid", 32'(bus.ex_valid), 32'd1);
        check_eq("add_ex_ctrl", 32'(bus.ex_ctrl), 32'h041);
        check_eq("add_ex_rs1", 32'(bus.ex_rs1), 32'd5);
        check_eq("add_ex_rd", 32'(bus.ex_rd), 32'd7);

        // Load with rd=0 never stalls.
        drive(1'b1, CtrlLoad, 1'b0, 5'd3, 5'd0, 5'd0, 1'b0);
        tick();
        drive(1'b1, CtrlAdd, 1'b0, 5'd0, 5'd0, 5'd9, 1'b0);
        #1;
        check_eq("rd0_no_stall", 32'(bus.pc_stall), 32'd0);
        tick();
        check_eq("rd0_captured_rd", 32'(bus.ex_rd), 32'd9);
        check_eq("rd0_count", 32'(bus.bubble_count), 32'd1);

        // rs2 match stalls too.
        drive(1'b1, CtrlLoad, 1'b0, 5'd4, 5'd4, 5'd8, 1'b0);
        tick();
        drive(1'b1, CtrlAdd, 1'b0, 5'd1, 5'd8, 5'd3, 1'b0);
        #1;
        check_eq("lu_rs2_stall", 32'(bus.pc_stall), 32'd1);
        tick();
        check_eq("lu_rs2_count", 32'(bus.bubble_count), 32'd2);
        tick();
        check_eq("rs2_add_rd", 32'(bus.ex_rd), 32'd3);
        drive(1'b0, CtrlAdd, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        check_eq("idle_bubble_valid", 32'(bus.ex_valid), 32'd0);
        check_eq("idle_bubble_ctrl", 32'(bus.ex_ctrl), 32'd0);
        check_eq("idle_no_count", 32'(bus.bubble_count), 32'd2);

        // Flush beats a halt in EX and a load-use.
        drive(1'b1, CtrlHLoad, 1'b0, 5'd0, 5'd0, 5'd5, 1'b0);
        tick();
        drive(1'b1, CtrlAdd, 1'b0, 5'd5, 5'd0, 5'd6, 1'b1);
        #1;
        check_eq("flush_no_stall", 32'(bus.pc_stall), 32'd0);
        tick();
        check_eq("flush_ex_valid", 32'(bus.ex_valid), 32'd0);
        check_eq("flush_halted", 32'(bus.halted), 32'd0);
        check_eq("flush_count", 32'(bus.bubble_count), 32'd3);

        // FENCE has its halt bit dropped when HALT_ON_FENCE=0.
        drive(1'b1, CtrlEcall, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        check_eq("fence_ex_valid", 32'(bus.ex_valid), 32'd1);
        check_eq("fence_ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
        drive(1'b0, 12'h000, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        check_eq("fence_no_stall", 32'(bus.pc_stall), 32'd0);
        tick();
        check_eq("fence_not_halted", 32'(bus.halted), 32'd0);

        // ECALL halts.
        drive(1'b1, CtrlEcall, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        drive(1'b1, CtrlAdd, 1'b0, 5'd1, 5'd2, 5'd3, 1'b0);
        #1;
        check_eq("hx_stall", 32'(bus.pc_stall), 32'd1);
        tick();
        check_eq("hx_halted", 32'(bus.halted), 32'd1);
        check_eq("hx_ex_valid", 32'(bus.ex_valid), 32'd0);
        check_eq("hx_count", 32'(bus.bubble_count), 32'd3);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, CtrlAdd, 1'b0, 5'd1, 5'd2, 5'd3, (i % 3) == 0);
            #1;
            check_eq("halted_stall", 32'(bus.pc_stall), 32'd1);
            tick();
            check_eq("halted_ex_valid", 32'(bus.ex_valid), 32'd0);
        end
        check_eq("halted_count_frozen", 32'(bus.bubble_count), 32'd3);
        check_eq("halted_sticky", 32'(bus.halted), 32'd1);

        // Asynchronous reset while halted.
        drive(1'b1, CtrlImm, 1'b0, 5'd1, 5'd2, 5'd4, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_halted", 32'(bus.halted), 32'd0);
        check_eq("arst_pc_stall", 32'(bus.pc_stall), 32'd0);
        check_eq("arst_count", 32'(bus.bubble_count), 32'd0);
        check_eq("arst_ex_valid", 32'(bus.ex_valid), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        check_eq("post_rst_ex_valid", 32'(bus.ex_valid), 32'd1);
        check_eq("post_rst_ex_ctrl", 32'(bus.ex_ctrl), 32'h071);
        check_eq("post_rst_ex_rd", 32'(bus.ex_rd), 32'd4);

        // Saturation: ID holds "lw x5, 0(x5)", alternating capture and stall.
        drive(1'b1, CtrlLoad, 1'b0, 5'd5, 5'd0, 5'd5, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 1) begin
                check_eq("sat_stall_seen", 32'(bus.pc_stall), 32'd1);
            end
            tick();
            check_eq($sformatf("sat_count_%0d", i), 32'(bus.bubble_count),
                     (i < 15) ? 32'(i) : 32'd15);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_ex_ctrl_stage.md
Name: id_ex_ctrl_stage

Overview:
ID/EX control pipeline register for the pipelined RV32I core, directly downstream of the decode control unit.
- Registers the decoded control bundle and register indices into EX.
- Detects load-use hazards and stalls the front end.
- Squashes wrong-path instructions on redirect.
- Latches a sticky halt when ECALL/EBREAK/FENCE reaches EX.
- Keeps a saturating bubble counter for performance visibility.

Parameters:
- CNT_W, 16, width of bubble_count (saturating).
- HALT_ON_FENCE, 1, when 0 the halt bit is ignored for FENCE (id_is_fence=1); ECALL/EBREAK always halt.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_ctrl  in  12  control bundle from the decode control unit (bit map in package).
- id_is_fence  in  1  ID instruction is FENCE/FENCE.TSO.
- id_rs1  in  5  source register 1.
- id_rs2  in  5  source register 2.
- id_rd  in  5  destination register.
- flush  in  1  branch/jump redirect resolved; ID and EX contents are wrong-path.
- ex_valid  out  1  EX holds a real instruction.
- ex_ctrl  out  12  registered control bundle.
- ex_rs1  out  5  registered rs1.
- ex_rs2  out  5  registered rs2.
- ex_rd  out  5  registered rd.
- pc_stall  out  1  hold PC and IF/ID this cycle (combinational).
- halted  out  1  core halted (sticky).
- bubble_count  out  CNT_W  bubbles inserted due to stall or flush.

Behaviour:
Reset (async, rst_n=0):
- ex_valid=0, ex_ctrl=0, ex_rs1/ex_rs2/ex_rd=0.
- halted=0, bubble_count=0, state=RUN.
- pc_stall=0 while in reset.

Bubble definition: ex_valid=0, ex_ctrl=0, ex_rd=0, ex_rs1/ex_rs2=0.

Load-use hazard (combinational): lu = ex_valid & ex_ctrl.MemRead & (ex_rd!=0) & id_valid & (ex_rd==id_rs1 | ex_rd==id_rs2).
- rs2 is compared regardless of format. The false stalls this causes are accepted.

Halt-in-EX: hx = ex_valid & ex_ctrl.halt.

States (two):
- RUN:
  - Priority per edge: flush > hx > lu > normal.
  - flush: EX loads bubble; bubble_count++; a halt currently in EX is discarded (wrong path); stay RUN; pc_stall=0.
  - hx (no flush): pc_stall=1; EX loads bubble (ID instruction squashed); next state HALTED; halted=1 from the next edge; bubble_count unchanged.
  - lu (no flush, no hx): pc_stall=1 for exactly one cycle; EX loads bubble; bubble_count++. The next cycle EX is no longer a load, so no further stall.
  - normal: EX loads the ID fields. ex_valid=id_valid. If id_valid=0, EX loads a bubble and bubble_count is unchanged.
  - FENCE with HALT_ON_FENCE=0: the halt bit is cleared on capture.
- HALTED:
  - pc_stall=1 continuously; EX loads bubble every edge; flush ignored; bubble_count frozen.
  - Exit only via rst_n.

Other rules:
- bubble_count saturates at all-ones and never wraps.
- Latency: ID→EX one cycle. pc_stall has zero cycle latency (same cycle as the hazard).
- Reset asserted mid-stall or mid-halt returns to RUN with all outputs cleared immediately (asynchronous).
- ex_rd=0 never triggers a stall, even for a load.

Decomposition:
- Shared package rv_ctrl_pkg:
  - Bit indices of the 12-bit control bundle: RegWrite[0], MemRead[1], MemWrite[2], MemtoReg[3], ALUSrc[4], ALUOp[6:5], Branch[7], jal[8], jalr[9], auipc[10], halt[11].
  - ALUOp encodings 00/01/10/11.
  - State encodings RUN=1'b0, HALTED=1'b1.
  - CTRL_W=12.
- One natural sub-module: hazard_detect, the purely combinational lu/hx logic. The register, FSM and counter stay in the top module.

Test Plan:
1. Load x5 in EX (MemRead=1, rd=5), ID add with rs1=5 → pc_stall=1 for one cycle; ex_valid=0 next edge; bubble_count 0→1; add enters EX one cycle later.
2. Load with rd=0 in EX, ID rs1=0 → no stall; ID captured normally; bubble_count=0.
3. flush=1 while a halt sits in EX and lu is true → EX bubble; halted stays 0; pc_stall=0; bubble_count+1.
4. ECALL (halt=1) enters EX → that cycle pc_stall=1; next edge halted=1, ex_valid=0. Then 10 cycles with id_valid=1 → ex_valid stays 0, bubble_count unchanged.
5. Preload the counter to all-ones (force or 2^CNT_W stalls with CNT_W=4) → the 16th and 17th stalls leave bubble_count=4'hF.
6. Assert rst_n=0 mid-HALTED between clock edges → outputs clear immediately. After release, a normal instruction with ctrl=12'h071 reaches EX one cycle later.
